// File: rtl/seg595_scan.sv
// rtl/seg595_scan.sv - six-digit 7-segment scanner driving two cascaded 74HC595s
// Optional build macro: LEADING_ZERO_BLANK_EN (blank digit 5 when hour_shi is zero).
module seg595_scan #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] sec_ge,
  input  logic [3:0] sec_shi,
  input  logic [3:0] min_ge,
  input  logic [3:0] min_shi,
  input  logic [3:0] hour_ge,
  input  logic [3:0] hour_shi,
  output logic       rclk_out,
  output logic       sclk_out,
  output logic       sdio_out,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_d;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic        half;
  logic [15:0] word_q;
  logic        div_end, bit_end;
  logic [3:0]  digit_bcd;
  logic [7:0]  seg, sel;
  logic [15:0] word;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 8'hC0;
      4'd1:    bcd_to_seg = 8'hF9;
      4'd2:    bcd_to_seg = 8'hA4;
      4'd3:    bcd_to_seg = 8'hB0;
      4'd4:    bcd_to_seg = 8'h99;
      4'd5:    bcd_to_seg = 8'h92;
      4'd6:    bcd_to_seg = 8'h82;
      4'd7:    bcd_to_seg = 8'hF8;
      4'd8:    bcd_to_seg = 8'h80;
      4'd9:    bcd_to_seg = 8'h90;
      default: bcd_to_seg = 8'hFF;
    endcase
  endfunction

  always_comb begin
    digit_bcd = 4'd0;
    case (digit_idx)
      3'd0:    digit_bcd = sec_ge;
      3'd1:    digit_bcd = sec_shi;
      3'd2:    digit_bcd = min_ge;
      3'd3:    digit_bcd = min_shi;
      3'd4:    digit_bcd = hour_ge;
      3'd5:    digit_bcd = hour_shi;
      default: digit_bcd = 4'd0;
    endcase
    seg = bcd_to_seg(digit_bcd);
    // digit_idx never exceeds 5, so select bits 7:6 always stay high
    sel = ~(8'h01 << digit_idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (digit_idx == 3'd5 && hour_shi == 4'd0) seg = 8'hFF;
`endif
    word = {seg, sel};
  end

  always_comb begin
    state_d = state;
    div_end = (div_cnt == DIV_LAST);
    bit_end = div_end && half && (bit_cnt == 4'd15);
    case (state)
      LOAD:    state_d = SHIFT;
      SHIFT:   if (bit_end) state_d = LATCH;
      LATCH:   if (div_end) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= LOAD;
      div_cnt    <= 8'd0;
      bit_cnt    <= 4'd0;
      half       <= 1'b0;
      word_q     <= 16'd0;
      rclk_out   <= 1'b0;
      sclk_out   <= 1'b0;
      sdio_out   <= 1'b0;
      digit_idx  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      frame_done <= 1'b0;
      div_cnt    <= (state == LOAD || div_end) ? 8'd0 : div_cnt + 8'd1;
      case (state)
        LOAD: begin
          word_q   <= word;
          sdio_out <= word[15];
          bit_cnt  <= 4'd0;
          half     <= 1'b0;
        end
        SHIFT: begin
          if (div_end) begin
            if (!half) begin
              half     <= 1'b1;
              sclk_out <= 1'b1;
            end else begin
              half     <= 1'b0;
              sclk_out <= 1'b0;
              // next bit goes out on the same edge that drops SCK
              if (bit_end) begin
                rclk_out <= 1'b1;
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                sdio_out <= word_q[4'd14 - bit_cnt];
              end
            end
          end
        end
        LATCH: begin
          if (div_end) begin
            rclk_out   <= 1'b0;
            digit_idx  <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
            frame_done <= (digit_idx == 3'd5);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg595_scan.sv
// tb/tb_seg595_scan.sv - scoreboard bench for seg595_scan
// Expected words are queued by the stimulus and popped by the monitor on each RCK rise.
module tb_seg595_scan;

  localparam int CD        = 2;
  localparam int DIGIT_CYC = 1 + 33 * CD;
  localparam int FRAME_CYC = 6 * DIGIT_CYC;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [15:0] BLANK_EXP = 16'hFFDF;
`else
  localparam logic [15:0] BLANK_EXP = 16'hC0DF;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [3:0] sec_ge, sec_shi, min_ge, min_shi, hour_ge, hour_shi;
  logic       rclk_out, sclk_out, sdio_out, frame_done;
  logic [2:0] digit_idx;
  logic       b_rclk, b_sclk, b_sdio, b_fd;
  logic [2:0] b_idx;

  always #5 clk_in = ~clk_in;

  seg595_scan #(.CLK_DIV(CD)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .sec_ge(sec_ge), .sec_shi(sec_shi), .min_ge(min_ge), .min_shi(min_shi),
    .hour_ge(hour_ge), .hour_shi(hour_shi),
    .rclk_out(rclk_out), .sclk_out(sclk_out), .sdio_out(sdio_out),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  seg595_scan #(.CLK_DIV(1)) u_dut_fast (
    .clk_in(clk_in), .rst_in(rst_in),
    .sec_ge(4'd8), .sec_shi(4'd8), .min_ge(4'd8), .min_shi(4'd8),
    .hour_ge(4'd8), .hour_shi(4'd0),
    .rclk_out(b_rclk), .sclk_out(b_sclk), .sdio_out(b_sdio),
    .digit_idx(b_idx), .frame_done(b_fd)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [18:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5);
    exp_q.push_back({3'd0, w0});
    exp_q.push_back({3'd1, w1});
    exp_q.push_back({3'd2, w2});
    exp_q.push_back({3'd3, w3});
    exp_q.push_back({3'd4, w4});
    exp_q.push_back({3'd5, w5});
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!frame_done && n < 1000);
    check("frame_done_seen", frame_done, 1'b1);
  endtask

  task automatic first_rck(input bit change_sec);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
      if (change_sec && n == 20) sec_ge = 4'd9;
    end while (!rclk_out && n < 300);
    check("first_rck_delay", n, 1 + 32 * CD);
  endtask

  // monitor state for both instances
  logic        sclk_q = 1'b0, rclk_q = 1'b0, b_sq = 1'b0, b_rq = 1'b0;
  logic [15:0] cap, b_cap;
  logic [18:0] e;
  int          nbits, rck_w, last_rck, last_fd, b_nbits, b_last;
  bit          have_rck, have_fd, b_have;

  always @(negedge clk_in) begin
    cyc++;
    if (rst_in) begin
      nbits = 0; rck_w = 0; have_rck = 0; have_fd = 0;
      b_nbits = 0; b_have = 0;
    end else begin
      if (sclk_out && !sclk_q) begin
        cap = {cap[14:0], sdio_out};
        nbits++;
      end
      if (rclk_out && !rclk_q) begin
        check("bits_per_word", nbits, 16);
        if (exp_q.size() == 0) begin
          check("unexpected_word", {13'd0, digit_idx, cap}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("word_digit_idx", digit_idx, e[18:16]);
          check("word_value", cap, e[15:0]);
        end
        if (have_rck) check("digit_period", cyc - last_rck, DIGIT_CYC);
        last_rck = cyc; have_rck = 1; nbits = 0; rck_w = 0;
      end
      if (rclk_out) rck_w++;
      if (!rclk_out && rclk_q) check("rck_width", rck_w, CD);
      if (frame_done) begin
        if (have_fd) check("frame_period", cyc - last_fd, FRAME_CYC);
        last_fd = cyc; have_fd = 1;
      end
      if (b_sclk && !b_sq) begin
        b_cap = {b_cap[14:0], b_sdio};
        b_nbits++;
      end
      if (b_rclk && !b_rq) begin
        check("fast_bits_per_word", b_nbits, 16);
        if (b_idx == 3'd5) check("fast_digit5_word", b_cap, BLANK_EXP);
        if (b_have) check("fast_digit_period", cyc - b_last, 34);
        b_last = cyc; b_have = 1; b_nbits = 0;
      end
    end
    sclk_q = sclk_out; rclk_q = rclk_out;
    b_sq = b_sclk; b_rq = b_rclk;
  end

  initial begin
    int n;
    rst_in = 1'b1;
    sec_ge = 4'd5; sec_shi = 4'd5; min_ge = 4'd4; min_shi = 4'd3; hour_ge = 4'd2; hour_shi = 4'd1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_rclk", rclk_out, 1'b0);
    check("rst_sclk", sclk_out, 1'b0);
    check("rst_sdio", sdio_out, 1'b0);
    check("rst_digit_idx", digit_idx, 3'd0);
    check("rst_frame_done", frame_done, 1'b0);

    // frame 1: sec_ge changes mid-shift of digit 0, new value only in frame 2
    push_frame(16'h92FE, 16'h92FD, 16'h99FB, 16'hB0F7, 16'hA4EF, 16'hF9DF);
    push_frame(16'h90FE, 16'h92FD, 16'h99FB, 16'hB0F7, 16'hA4EF, 16'hF9DF);
    rst_in = 1'b0;
    first_rck(1'b1);

    wait_fd();
    repeat (150) @(negedge clk_in);
    min_ge = 4'hC;
    push_frame(16'h90FE, 16'h92FD, 16'hFFFB, 16'hB0F7, 16'hA4EF, 16'hF9DF);
    wait_fd();
    exp_q.push_back({3'd0, 16'h90FE});
    exp_q.push_back({3'd1, 16'h92FD});
    wait_fd();

    // reset during bit 7 of digit 2
    repeat (164) @(negedge clk_in);
    check("pre_reset_digit_idx", digit_idx, 3'd2);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_rclk", rclk_out, 1'b0);
    check("midrst_sclk", sclk_out, 1'b0);
    check("midrst_sdio", sdio_out, 1'b0);
    check("midrst_digit_idx", digit_idx, 3'd0);
    check("midrst_frame_done", frame_done, 1'b0);
    repeat (2) @(negedge clk_in);
    push_frame(16'h90FE, 16'h92FD, 16'hFFFB, 16'hB0F7, 16'hA4EF, 16'hF9DF);
    rst_in = 1'b0;
    first_rck(1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg595_scan.md
# seg595_scan

Display back-end for the digital clock. Takes the six BCD time digits produced by the clock counter stage and time-multiplexes them onto a six-digit common-anode 7-segment display through two cascaded 74HC595 shift registers. Each digit refresh serialises one 16-bit word of segment plus digit-select bits, then pulses the storage clock. The block runs continuously from reset with no handshake to the upstream counter.

## Interface
Parameters:
- CLK_DIV, 2: clk_in cycles per SCK half-period; legal values 1..255.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-high.
- sec_ge  input  4  seconds units digit, BCD.
- sec_shi  input  4  seconds tens digit, BCD.
- min_ge  input  4  minutes units digit, BCD.
- min_shi  input  4  minutes tens digit, BCD.
- hour_ge  input  4  hours units digit, BCD.
- hour_shi  input  4  hours tens digit, BCD.
- rclk_out  output  1  74HC595 RCK (storage latch).
- sclk_out  output  1  74HC595 SCK (shift clock).
- sdio_out  output  1  74HC595 SER (serial data).
- digit_idx  output  3  index of the digit currently being sent, 0..5.
- frame_done  output  1  one-cycle pulse after digit 5 has been latched.

## Operation
- Digit index 0..5 maps to sec_ge, sec_shi, min_ge, min_shi, hour_ge, hour_shi.
- Segment byte seg[7:0] = {dp,g,f,e,d,c,b,a}, active-low. dp is always 1 (off).
- BCD-to-segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Inputs 10..15 produce FF (blank).
- Select byte sel[7:0] is active-low: bit k=0 only for k=digit_idx. Bits 7:6 are always 1. Example: digit 0 gives FE.
- Shift word w[15:0] = {seg, sel}, sent MSB first, so seg ends in the far 595.
- FSM states:
  - LOAD (1 cycle): sample the selected digit and build w.
  - SHIFT (16 bits × 2·CLK_DIV cycles).
  - LATCH (CLK_DIV cycles).
  - Then return to LOAD with digit_idx+1; digit_idx wraps from 5 to 0.
- Only the selected digit is sampled, and only in LOAD. Input changes during SHIFT or LATCH do not affect the word in flight.

## Timing
- Reset: rclk_out=0, sclk_out=0, sdio_out=0, digit_idx=0, frame_done=0, FSM=LOAD. The first LOAD happens in the cycle after rst_in deasserts.
- Reset mid-operation: all outputs return to their reset values on the next edge. The partial word is abandoned and digit_idx restarts at 0.
- Each bit period is 2·CLK_DIV cycles:
  - First CLK_DIV cycles: sclk_out=0, and sdio_out updates to the bit on the first cycle of the period.
  - Last CLK_DIV cycles: sclk_out=1. The rising SCK edge occurs CLK_DIV cycles after sdio_out changes.
  - sdio_out is stable for the whole bit period.
- LATCH: sclk_out=0 and rclk_out=1 for CLK_DIV cycles; rclk_out returns to 0 on entry to LOAD.
- Per-digit period is 1+33·CLK_DIV cycles (67 at the default). Frame period is 6·(1+33·CLK_DIV) cycles (402 at the default).
- frame_done is high for the single cycle in which the FSM enters LOAD with digit_idx wrapping 5→0.
- sdio_out holds its last value outside SHIFT.

## Configuration
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when hour_shi==0, digit 5 is sent with seg=FF and sel=DF, so the digit is selected but blank.
- Not defined: hour_shi==0 displays "0" (C0), like any other digit.
- Frame timing is identical in both builds.

## Test plan
- Reset: hold rst_in for 3 cycles -> all outputs 0 and digit_idx=0. The first RCK rising edge appears 1+32·CLK_DIV cycles after release.
- Digit 0: sec_ge=5, CLK_DIV=2 -> SER sampled at 16 SCK rising edges equals 0x92FE, MSB first. Exactly one RCK pulse, 2 cycles wide.
- Full frame: digits 1,2,3,4,5,9 (hour_shi..sec_ge) -> words F9DF, A4EF, B0F7, 99FB, 92FD, 90FE in order digit 5..0. frame_done pulses every 402 cycles.
- Invalid BCD: min_ge=4'hC -> digit 2 word FFFB.
- Stability and reset: change sec_ge mid-SHIFT -> the in-flight word is unchanged and the new value appears next frame. Assert rst_in at bit 7 -> outputs zero next cycle and the sequence restarts from digit 0.
- Blanking: hour_shi=0, CLK_DIV=1:
  - With LEADING_ZERO_BLANK_EN -> digit 5 word FFDF.
  - Without it -> C0DF.
  - Per-digit period is 34 cycles in both builds.
